// File: rtl/dmem_uart_tx.sv
// dmem_uart_tx: dmem-mapped UART transmitter with a small TX FIFO.
// Register map by I_addr[3:2]: 0 TXDATA (wo), 1 STATUS (ro), 2 BAUDDIV (rw), 3 reserved.
// Define UART_PARITY_EN to add an even-parity bit between DATA and STOP.
module dmem_uart_tx #(
  parameter int CLK_HZ     = 48000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_sel,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_data,
  input  logic [3:0]  I_mask,
  input  logic        I_we,
  output logic [31:0] O_data,
  output logic        O_stall,
  output logic        O_tx,
  output logic        O_irq
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DIV0    = 16'(CLK_HZ / BAUD);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t state_q, state_d;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr, level;
  logic        full, empty, push, pop, wr_acc;
  logic [7:0]  head;
  logic [15:0] div_q, div_new;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        bit_end, busy;
  logic [3:0]  lvl4;
`ifdef UART_PARITY_EN
  logic        parity_q;
`endif

  logic unused_bits;
  assign unused_bits = &{1'b0, I_addr[31:4], I_addr[1:0], I_data[31:16], I_mask[3:2]};

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign lvl4    = 4'(level);
  assign head    = mem[rd_ptr[PW-1:0]];
  assign wr_acc  = I_sel && I_we && (I_addr[3:2] == 2'd0) && I_mask[0];
  assign push    = wr_acc && !full;
  assign O_stall = wr_acc && full;
  assign pop     = (state_q == ST_IDLE) && !empty;
  assign bit_end = (baud_cnt == '0);
  assign O_irq   = empty && !busy;

  // FIFO storage (no reset needed; validity tracked by pointers)
  always_ff @(posedge I_clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= I_data[7:0];
  end

  // FIFO pointers
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // BAUDDIV byte-merge with clamp to a minimum of 2
  always_comb begin
    div_new = {I_mask[1] ? I_data[15:8] : div_q[15:8],
               I_mask[0] ? I_data[7:0]  : div_q[7:0]};
    if (div_new < 16'd2) div_new = 16'd2;
  end

  // BAUDDIV register; counters pick it up at the next bit reload
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) div_q <= DIV0;
    else if (I_sel && I_we && (I_addr[3:2] == 2'd2) && (|I_mask[1:0])) div_q <= div_new;
  end

  // FSM state register
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!empty) state_d = ST_START;
      ST_START:  if (bit_end) state_d = ST_DATA;
`ifdef UART_PARITY_EN
      ST_DATA:   if (bit_end && bit_cnt == 3'd7) state_d = ST_PARITY;
      ST_PARITY: if (bit_end) state_d = ST_STOP;
`else
      ST_DATA:   if (bit_end && bit_cnt == 3'd7) state_d = ST_STOP;
`endif
      ST_STOP:   if (bit_end) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Shifter, bit counter and baud down-counter
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (pop) begin
      shreg    <= head;
      baud_cnt <= div_q - 16'd1;
      bit_cnt  <= '0;
`ifdef UART_PARITY_EN
      parity_q <= ^head;
`endif
    end else if (state_q != ST_IDLE) begin
      if (bit_end) begin
        baud_cnt <= div_q - 16'd1;
        if (state_q == ST_DATA) begin
          shreg   <= {1'b0, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt - 16'd1;
      end
    end
  end

  // FSM outputs: line level and busy, decoded from the registered state
  always_comb begin
    O_tx = 1'b1;
    busy = 1'b1;
    case (state_q)
      ST_IDLE:   busy = 1'b0;
      ST_START:  O_tx = 1'b0;
      ST_DATA:   O_tx = shreg[0];
`ifdef UART_PARITY_EN
      ST_PARITY: O_tx = parity_q;
`endif
      default:   O_tx = 1'b1;
    endcase
  end

  // Read data mux
  always_comb begin
    O_data = '0;
    if (I_sel) begin
      case (I_addr[3:2])
        2'd1:    O_data = {24'd0, lvl4, 1'b0, empty, full, busy};
        2'd2:    O_data = {16'd0, div_q};
        default: O_data = '0;
      endcase
    end
  end

endmodule
